// File: rtl/pipe_pkg.sv
// Shared types for the five-stage pipeline sequencing controller.
package pipe_pkg;

  // Operand source selected for an ID-stage register read.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  // ebreak drain-and-halt sequencing.
  typedef enum logic [1:0] {
    HS_RUN   = 2'd0,
    HS_DRAIN = 2'd1,
    HS_HALT  = 2'd2
  } halt_state_t;

  // One shadow-pipeline slot: what the instruction in that stage will do.
  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       wb;
    logic       load;
    logic       mem;
  } sb_entry_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A stage can supply src when it will write a non-zero register equal to src.
  function automatic logic fwd_hit(input sb_entry_t e, input logic [4:0] src);
    return e.vld & e.wb & (e.rd == src) & (src != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_sb_stage.sv
// One shadow-pipeline stage register: holds, takes a bubble, or loads the
// entry from the previous stage. Only the valid bit is reset; the payload is
// meaningless while vld is low.
module hazard_sb_stage
  import pipe_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_hold,
  input  logic      i_bubble,
  input  sb_entry_t i_d,
  output sb_entry_t o_q
);

  logic       r_vld;
  logic [4:0] r_rd;
  logic       r_wb;
  logic       r_load;
  logic       r_mem;

  // Valid bit: cleared by reset or a bubble, frozen while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
    end else if (!i_hold) begin
      r_vld <= i_d.vld & ~i_bubble;
    end
  end

  // Payload follows the upstream entry whenever the stage advances.
  always_ff @(posedge clk) begin
    if (!i_hold) begin
      r_rd   <= i_d.rd;
      r_wb   <= i_d.wb;
      r_load <= i_d.load;
      r_mem  <= i_d.mem;
    end
  end

  assign o_q = {r_vld, r_rd, r_wb, r_load, r_mem};

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the IF/ID/EX/MEM/WB core: shadow
// pipeline of in-flight destinations, stall/flush/bubble generation,
// operand forwarding selects, MEM handshake and ebreak drain-and-halt.
module hazard_ctrl
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_wb_en,
  input  logic       id_load_en,
  input  logic       id_store_en,
  input  logic       id_ebreak,
  input  logic       ex_redirect,
  input  logic       lsu_ack,
  output logic       if_stall,
  output logic       id_stall,
  output logic       ex_stall,
  output logic       mem_stall,
  output logic       if_flush,
  output logic       ex_bubble,
  output logic       wb_bubble,
  output fwd_sel_t   fwd_rs1_sel,
  output fwd_sel_t   fwd_rs2_sel,
  output logic       lsu_req,
  output logic       halted
);

  sb_entry_t   w_id_entry;
  sb_entry_t   w_ex;
  sb_entry_t   w_mem;
  sb_entry_t   w_wb;
  logic        w_mem_wait;
  logic        w_redirect;
  logic        w_load_use;
  logic        w_ex_bubble_in;
  halt_state_t r_state;
  halt_state_t w_state_nxt;

  // First older stage able to supply the operand wins; a load still in EX
  // has no result yet and is skipped (the load-use stall covers it).
  function automatic fwd_sel_t pick_fwd(input logic used, input logic [4:0] src,
                                        input sb_entry_t ex, input sb_entry_t mem,
                                        input sb_entry_t wb);
    if (!used)                          return FWD_RF;
    if (fwd_hit(ex, src) && !ex.load)   return FWD_EX;
    if (fwd_hit(mem, src))              return FWD_MEM;
    if (fwd_hit(wb, src))               return FWD_WB;
    return FWD_RF;
  endfunction

  assign lsu_req    = w_mem.vld & w_mem.mem;
  assign w_mem_wait = lsu_req & ~lsu_ack;
  assign w_redirect = ex_redirect & ~w_mem_wait;
  assign w_load_use = id_valid & w_ex.vld & w_ex.load & (w_ex.rd != REG_ZERO) &
                      ((id_rs1_used & (id_rs1 == w_ex.rd)) |
                       (id_rs2_used & (id_rs2 == w_ex.rd)));

  assign fwd_rs1_sel = pick_fwd(id_rs1_used, id_rs1, w_ex, w_mem, w_wb);
  assign fwd_rs2_sel = pick_fwd(id_rs2_used, id_rs2, w_ex, w_mem, w_wb);
  assign halted      = (r_state == HS_HALT);

  // Stage control and halt FSM next state, highest priority first.
  always_comb begin
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    ex_stall    = 1'b0;
    mem_stall   = 1'b0;
    if_flush    = 1'b0;
    ex_bubble   = 1'b0;
    wb_bubble   = 1'b0;
    w_state_nxt = r_state;
    if (w_mem_wait) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_stall = 1'b1;
      wb_bubble = 1'b1;
    end else if (r_state == HS_HALT) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_stall = 1'b1;
    end else if (w_redirect) begin
      if_flush  = 1'b1;
      ex_bubble = 1'b1;
      // An older branch was taken: the ebreak being drained was wrong-path.
      if (r_state == HS_DRAIN) w_state_nxt = HS_RUN;
    end else if (r_state == HS_DRAIN) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_bubble = 1'b1;
      if (!w_ex.vld && !w_mem.vld && !w_wb.vld) w_state_nxt = HS_HALT;
    end else if (w_load_use) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_bubble = 1'b1;
    end else if (id_valid && id_ebreak) begin
      w_state_nxt = HS_DRAIN;
    end
  end

  // Halt FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= HS_RUN;
    else        r_state <= w_state_nxt;
  end

  // The ebreak itself has no architectural effect, so it enters EX as a
  // bubble; the drain only waits for the older instructions.
  assign w_id_entry     = {id_valid, id_rd, id_wb_en, id_load_en, id_load_en | id_store_en};
  assign w_ex_bubble_in = ex_bubble | ~id_valid | id_ebreak;

  hazard_sb_stage u_sb_ex (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hold   (ex_stall),
    .i_bubble (w_ex_bubble_in),
    .i_d      (w_id_entry),
    .o_q      (w_ex)
  );

  hazard_sb_stage u_sb_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hold   (mem_stall),
    .i_bubble (1'b0),
    .i_d      (w_ex),
    .o_q      (w_mem)
  );

  hazard_sb_stage u_sb_wb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hold   (1'b0),
    .i_bubble (wb_bubble),
    .i_d      (w_mem),
    .o_q      (w_wb)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver pushes a hand-computed
// expected output vector per cycle, the monitor pops and compares it on the
// falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_wb_en;
  logic       id_load_en;
  logic       id_store_en;
  logic       id_ebreak;
  logic       ex_redirect;
  logic       lsu_ack;
  logic       if_stall;
  logic       id_stall;
  logic       ex_stall;
  logic       mem_stall;
  logic       if_flush;
  logic       ex_bubble;
  logic       wb_bubble;
  logic [1:0] fwd_rs1_sel;
  logic [1:0] fwd_rs2_sel;
  logic       lsu_req;
  logic       halted;

  hazard_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_wb_en    (id_wb_en),
    .id_load_en  (id_load_en),
    .id_store_en (id_store_en),
    .id_ebreak   (id_ebreak),
    .ex_redirect (ex_redirect),
    .lsu_ack     (lsu_ack),
    .if_stall    (if_stall),
    .id_stall    (id_stall),
    .ex_stall    (ex_stall),
    .mem_stall   (mem_stall),
    .if_flush    (if_flush),
    .ex_bubble   (ex_bubble),
    .wb_bubble   (wb_bubble),
    .fwd_rs1_sel (fwd_rs1_sel),
    .fwd_rs2_sel (fwd_rs2_sel),
    .lsu_req     (lsu_req),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [12:0] exp;
  } chk_t;

  chk_t sb_q[$];
  chk_t mon_item;
  int   n_cmp = 0;
  int   n_bad = 0;

  // {if_stall,id_stall,ex_stall,mem_stall,if_flush,ex_bubble,wb_bubble,fwd1,fwd2,lsu_req,halted}
  logic [12:0] act;
  assign act = {if_stall, id_stall, ex_stall, mem_stall, if_flush, ex_bubble, wb_bubble,
                fwd_rs1_sel, fwd_rs2_sel, lsu_req, halted};

  function automatic logic [12:0] ev(input logic [3:0] st, input logic fl, input logic eb,
                                     input logic wbb, input logic [1:0] f1,
                                     input logic [1:0] f2, input logic rq, input logic hl);
    return {st, fl, eb, wbb, f1, f2, rq, hl};
  endfunction

  task automatic cyc(input string nm, input logic [12:0] e);
    chk_t c;
    c.name = nm;
    c.exp  = e;
    sb_q.push_back(c);
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_rd = 5'd0; id_wb_en = 1'b0; id_load_en = 1'b0; id_store_en = 1'b0; id_ebreak = 1'b0;
  endtask

  task automatic ins(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic wb,
                     input logic ld, input logic st, input logic eb);
    id_valid = 1'b1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_wb_en = wb; id_load_en = ld; id_store_en = st; id_ebreak = eb;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      nop();
      cyc("idle", 13'd0);
    end
  endtask

  // Monitor: every output is combinational, so one expected vector per cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_item = sb_q.pop_front();
      n_cmp++;
      if (act !== mon_item.exp) begin
        n_bad++;
        $display("FAIL %s: got %b expected %b", mon_item.name, act, mon_item.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ex_redirect = 1'b0; lsu_ack = 1'b1;
    nop();
    @(posedge clk);
    #1;
    cyc("reset", 13'd0);
    rst_n = 1'b1;
    idle(1);

    // lw x5 ; add x6,x5,x1
    ins(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0); cyc("lu_issue", 13'd0);
    ins(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0); cyc("lu_stall", ev(4'b1100, 0, 1, 0, 0, 0, 0, 0));
    cyc("lu_fwd", ev(4'b0000, 0, 0, 0, 2'd2, 2'd0, 1, 0));
    idle(3);

    // addi x5 ; add x7,x5,x5 ; add x8,x5,x7 ; add x9,x5,x0
    ins(5'd0, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0); cyc("fx_issue", 13'd0);
    ins(5'd5, 1, 5'd5, 1, 5'd7, 1, 0, 0, 0); cyc("fwd_ex", ev(4'b0000, 0, 0, 0, 2'd1, 2'd1, 0, 0));
    ins(5'd5, 1, 5'd7, 1, 5'd8, 1, 0, 0, 0); cyc("fwd_mix", ev(4'b0000, 0, 0, 0, 2'd2, 2'd1, 0, 0));
    ins(5'd5, 1, 5'd0, 1, 5'd9, 1, 0, 0, 0); cyc("fwd_wb", ev(4'b0000, 0, 0, 0, 2'd3, 2'd0, 0, 0));
    idle(3);

    // addi x0 ; add x7,x0,x0 : writes to x0 are never forwarded
    ins(5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0); cyc("x0_issue", 13'd0);
    ins(5'd0, 1, 5'd0, 1, 5'd7, 1, 0, 0, 0); cyc("fwd_x0", 13'd0);
    idle(3);

    // addi x5 ; instruction with rs2 field = x5 but rs2 not read
    ins(5'd0, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0); cyc("un_issue", 13'd0);
    ins(5'd5, 1, 5'd5, 0, 5'd6, 1, 0, 0, 0); cyc("fwd_unused", ev(4'b0000, 0, 0, 0, 2'd1, 2'd0, 0, 0));
    idle(3);

    // store in MEM, ack delayed 3 cycles, redirect held during the wait
    ins(5'd2, 1, 5'd3, 1, 5'd0, 0, 0, 1, 0); cyc("st_issue", 13'd0);
    nop(); cyc("st_ex", 13'd0);
    lsu_ack = 1'b0; ex_redirect = 1'b1;
    cyc("mw1", ev(4'b1111, 0, 0, 1, 0, 0, 1, 0));
    cyc("mw2", ev(4'b1111, 0, 0, 1, 0, 0, 1, 0));
    cyc("mw3", ev(4'b1111, 0, 0, 1, 0, 0, 1, 0));
    lsu_ack = 1'b1;
    cyc("mw_ack_redir", ev(4'b0000, 1, 1, 0, 0, 0, 1, 0));
    ex_redirect = 1'b0;
    cyc("mw_after", 13'd0);
    idle(3);

    // reset mid-access drops lsu_req at once; a late ack is ignored
    ins(5'd2, 1, 5'd3, 1, 5'd0, 0, 0, 1, 0); cyc("st2_issue", 13'd0);
    nop(); cyc("st2_ex", 13'd0);
    lsu_ack = 1'b0;
    cyc("rst_mw", ev(4'b1111, 0, 0, 1, 0, 0, 1, 0));
    rst_n = 1'b0;
    cyc("rst_mid", 13'd0);
    rst_n = 1'b1; lsu_ack = 1'b1;
    cyc("rst_late_ack", 13'd0);
    idle(1);

    // redirect coincident with load-use: the redirect wins
    ins(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0); cyc("rl_issue", 13'd0);
    ins(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0); ex_redirect = 1'b1;
    cyc("redir_wins", ev(4'b0000, 1, 1, 0, 0, 0, 0, 0));
    ex_redirect = 1'b0; nop();
    cyc("rl_ld_mem", ev(4'b0000, 0, 0, 0, 0, 0, 1, 0));
    idle(3);

    // ebreak with empty pipe, then redirect in DRAIN returns to RUN
    ins(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1); cyc("eb2_issue", 13'd0);
    nop(); ex_redirect = 1'b1;
    cyc("drain_redir", ev(4'b0000, 1, 1, 0, 0, 0, 0, 0));
    ex_redirect = 1'b0;
    cyc("redir_run1", 13'd0);
    cyc("redir_run2", 13'd0);
    idle(2);

    // ebreak with two older instructions in flight
    ins(5'd0, 1, 5'd0, 0, 5'd1, 1, 0, 0, 0); cyc("eb_old1", 13'd0);
    ins(5'd0, 1, 5'd0, 0, 5'd2, 1, 0, 0, 0); cyc("eb_old2", 13'd0);
    ins(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1); cyc("eb_issue", 13'd0);
    ins(5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 0);
    cyc("drain1", ev(4'b1100, 0, 1, 0, 0, 0, 0, 0));
    cyc("drain2", ev(4'b1100, 0, 1, 0, 0, 0, 0, 0));
    cyc("drain3", ev(4'b1100, 0, 1, 0, 0, 0, 0, 0));
    cyc("halt1", ev(4'b1111, 0, 0, 0, 0, 0, 0, 1));
    cyc("halt2", ev(4'b1111, 0, 0, 0, 0, 0, 0, 1));
    cyc("halt3", ev(4'b1111, 0, 0, 0, 0, 0, 0, 1));
    rst_n = 1'b0; nop();
    cyc("halt_rst", 13'd0);
    rst_n = 1'b1;
    cyc("after_rst", 13'd0);
    ins(5'd0, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0); cyc("run_issue", 13'd0);
    ins(5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0);
    cyc("run_again", ev(4'b0000, 0, 0, 0, 2'd1, 2'd0, 0, 0));
    idle(2);

    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage core (IF/ID/EX/MEM/WB). It takes the decoded control bits of the instruction in ID and tracks the destination and writeback class of every instruction in EX, MEM and WB in an internal shadow pipeline. From that state it drives per-stage stall, flush and bubble, operand-forwarding selects, and the MEM-stage load/store request/acknowledge handshake. It also runs the ebreak drain-and-halt state machine.

## Interface
- No parameters; XLEN-independent (register indices only).
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in 5 each: source indices.
- `id_rs1_used`, `id_rs2_used` in 1 each: source is actually read (false for U/J types and for rs2 of I types).
- `id_rd` in 5: destination index.
- `id_wb_en`, `id_load_en`, `id_store_en`, `id_ebreak` in 1 each: decoder outputs.
- `ex_redirect` in 1: taken branch or jump resolved in EX.
- `lsu_ack` in 1: memory completes the current MEM access.
- `if_stall`, `id_stall`, `ex_stall`, `mem_stall` out 1 each: hold the stage register.
- `if_flush` out 1: kill the IF/ID register.
- `ex_bubble` out 1: load a NOP into ID/EX.
- `wb_bubble` out 1: load a NOP into MEM/WB.
- `fwd_rs1_sel`, `fwd_rs2_sel` out 2 each: 0 regfile, 1 EX result, 2 MEM result, 3 WB result.
- `lsu_req` out 1: MEM-stage access pending.
- `halted` out 1: core stopped after ebreak.

## Operation
- Shadow stages EX, MEM, WB each hold {vld, rd, wb, load, mem}. On advance: EX←ID (or bubble), MEM←EX, WB←MEM (or bubble). Reset clears every vld.
- `lsu_req` = mem.vld & mem.mem. While `lsu_req` & !`lsu_ack` (mem_wait):
  - all four stalls high, `wb_bubble` high;
  - WB shadow takes a bubble.
- Load-use hazard: id_valid & ex.vld & ex.load & ex.rd≠0, where a used source equals ex.rd. Effect: `if_stall`, `id_stall` and `ex_bubble` high; EX shadow takes a bubble.
- Redirect (`ex_redirect` & !mem_wait): `if_flush` high, `ex_bubble` high; the ID instruction is discarded and no hazard is evaluated.
- Priority: mem_wait > redirect > load-use > normal advance. A redirect during mem_wait is held by the stalled EX and takes effect in the cycle `lsu_ack` arrives.
- Forwarding per source: the first match among EX (not load), MEM, WB wins, requiring vld & wb & rd==src & rd≠0. Otherwise the select is 0. Unused sources select 0.
- Halt FSM states:
  - RUN → DRAIN when id_valid & id_ebreak advance into EX. From then IF/ID are frozen (`if_stall`, `id_stall` high) and bubbles enter EX.
  - DRAIN → HALT when EX, MEM and WB shadows are all invalid.
  - HALT is terminal until reset. In HALT `halted`=1 and all stalls are high.
  - A redirect in DRAIN (older branch taken) returns the FSM to RUN; the ebreak was on the wrong path.

## Timing
- All hazard, stall and forward outputs are combinational from shadow registers and ID inputs, valid in the same cycle. Shadow state and FSM update on the rising edge.
- Load-use costs exactly 1 bubble. Redirect costs 2 killed slots (IF and ID). A mem wait costs N cycles for ack at cycle N.
- Reset values: all stalls, flush and bubbles 0; `lsu_req` 0; fwd selects 0; `halted` 0; FSM in RUN.
- Asserting `rst_n` mid-access drops `lsu_req` immediately (asynchronous). A late `lsu_ack` after reset is ignored because mem.vld=0.
- `lsu_ack` without `lsu_req` is ignored.

## Structure
- A shared package `pipe_pkg` holds:
  - fwd_sel enum (FWD_RF, FWD_EX, FWD_MEM, FWD_WB);
  - halt FSM state enum;
  - the shadow-entry struct.
- One sub-module, `hazard_sb_stage`: the shadow register with vld/rd/wb/load/mem, hold and bubble inputs, and async reset. It is instantiated three times.

## Test plan
- `lw x5` followed by `add x6,x5,x1`: one cycle with `ex_bubble`=1 and `if_stall`=`id_stall`=1, then `fwd_rs1_sel`=2.
- `addi x5`, then `add x7,x5,x5`: `fwd_rs1_sel`=`fwd_rs2_sel`=1, no stall. The same sequence with rd=x0 gives selects 0.
- Store in MEM with `lsu_ack` delayed 3 cycles: `lsu_req` high for 4 cycles, all stalls high for 3, and `wb_bubble` for 3.
- `ex_redirect` coincident with a load-use in ID: `if_flush`=1 and `ex_bubble`=1 with `if_stall`=0. The redirect wins.
- ebreak with 2 older instructions in flight: DRAIN for 3 cycles, then `halted`=1 and held. Pulsing `rst_n` low clears `halted` and the FSM returns to RUN.
